// File: rtl/siren_pkg.sv
// Shared types and defaults for the siren detector.
// The FSM state enum, the 18-bit period type and the default
// acceptance window and timeout live here.
package siren_pkg;

  localparam int PERIOD_W = 18;

  typedef logic [PERIOD_W-1:0] period_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Default half-period window, in clock cycles (both ends accepted).
  localparam period_t DEF_MIN_HALF = 18'd65000;
  localparam period_t DEF_MAX_HALF = 18'd131072;

  // Cycles without an edge before an acquisition or lock is abandoned.
  localparam period_t DEF_TIMEOUT  = 18'd262143;

  // Consecutive in-window half-periods needed to declare a siren.
  localparam logic [3:0] DEF_LOCK_COUNT = 4'd8;

  // Saturation value of the interval counter.
  localparam period_t PERIOD_MAX = {PERIOD_W{1'b1}};

  // Inclusive window test used on every captured interval.
  function automatic logic in_window(input period_t v,
                                     input period_t lo,
                                     input period_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/siren_detector_sync_edge.sv
// sync_edge: brings the asynchronous tone line into the clock domain
// through two flops, keeps a delayed copy, and emits a registered
// one-cycle strobe whenever the synchronized level changes.
// A tone_in transition shows up on o_edge three clocks later.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_dly;
  logic r_edge;
  logic w_change;

  // Level change between the synchronized sample and its delayed copy.
  assign w_change = r_sync2 ^ r_dly;

  // Two-flop synchronizer, delay flop and registered edge strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
      r_edge  <= w_change;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/siren_detector.sv
// siren_detector: measures edge-to-edge intervals of a square-wave tone
// and declares a siren once LOCK_COUNT consecutive half-periods fall
// inside [MIN_HALF, MAX_HALF]. Silence for TIMEOUT cycles drops back to
// IDLE.
//
// Optional build macro SIREN_SWEEP_CHECK_EN: while locked, 32 identical
// consecutive captures (a constant tone rather than a sweeping siren)
// force a return to ACQUIRE. Without the macro a steady in-window tone
// stays locked indefinitely.
//
// Output handshake: period_valid is a one-cycle valid strobe with no
// ready/backpressure; half_period is stable from that strobe until the
// next one, so a consumer must sample it on the strobe or later.
// o_dbg_state exposes the FSM state for observation.
module siren_detector
  import siren_pkg::*;
#(
  parameter period_t    MIN_HALF   = DEF_MIN_HALF,
  parameter period_t    MAX_HALF   = DEF_MAX_HALF,
  parameter period_t    TIMEOUT    = DEF_TIMEOUT,
  parameter logic [3:0] LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tone_in,
  output logic                siren_detected,
  output logic [PERIOD_W-1:0] half_period,
  output logic                period_valid,
  output state_t              o_dbg_state
);

  logic       w_edge;
  logic       w_in_window;
  logic       w_timeout;
  logic       w_capture;
  logic       w_sweep_drop;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_good;
  logic [3:0] w_good_next;
  logic [3:0] w_good_inc;
  period_t    r_count;
  period_t    r_half_period;
  logic       r_period_valid;
  logic       r_siren;

  sync_edge u_sync_edge (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_async (tone_in),
    .o_edge  (w_edge)
  );

  // The counter holds the interval since the previous edge at the
  // moment the edge strobe is seen, so it is the measurement itself.
  assign w_in_window = in_window(r_count, MIN_HALF, MAX_HALF);
  assign w_timeout   = (r_count == TIMEOUT);
  assign w_good_inc  = r_good + 4'd1;

`ifdef SIREN_SWEEP_CHECK_EN
  localparam logic [5:0] SWEEP_RUN = 6'd32;

  logic [5:0] r_run;
  logic [5:0] w_run_next;

  // Run length of identical captures seen while locked.
  always_comb begin
    w_run_next   = r_run;
    w_sweep_drop = 1'b0;
    if ((r_state == LOCKED) && w_edge && w_in_window) begin
      if ((r_run != 6'd0) && (r_count == r_half_period)) begin
        w_run_next = r_run + 6'd1;
      end else begin
        w_run_next = 6'd1;
      end
      if (w_run_next == SWEEP_RUN) begin
        w_sweep_drop = 1'b1;
      end
    end
  end

  // Run length only survives while the FSM stays locked.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run <= 6'd0;
    end else if (w_state_next == LOCKED) begin
      r_run <= w_run_next;
    end else begin
      r_run <= 6'd0;
    end
  end
`else
  assign w_sweep_drop = 1'b0;
`endif

  // Next-state and good-count logic; an edge takes priority over timeout.
  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good;
    w_capture    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // First edge only starts the interval; nothing is measured yet.
        if (w_edge) begin
          w_state_next = ACQUIRE;
          w_good_next  = 4'd0;
        end
      end
      ACQUIRE: begin
        if (w_edge) begin
          w_capture = 1'b1;
          if (w_in_window) begin
            w_good_next = w_good_inc;
            if (w_good_inc >= LOCK_COUNT) begin
              w_state_next = LOCKED;
            end
          end else begin
            w_good_next = 4'd0;
          end
        end else if (w_timeout) begin
          w_state_next = IDLE;
          w_good_next  = 4'd0;
        end
      end
      LOCKED: begin
        if (w_edge) begin
          w_capture = 1'b1;
          if (!w_in_window || w_sweep_drop) begin
            w_state_next = ACQUIRE;
            w_good_next  = 4'd0;
          end
        end else if (w_timeout) begin
          w_state_next = IDLE;
          w_good_next  = 4'd0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_good_next  = 4'd0;
      end
    endcase
  end

  // FSM state and good counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_good  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_good  <= w_good_next;
    end
  end

  // Interval counter: restarts at 1 on an edge, otherwise saturates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_edge) begin
      r_count <= period_t'(1);
    end else if (r_count != PERIOD_MAX) begin
      r_count <= r_count + period_t'(1);
    end
  end

  // Capture of the measured half-period and its valid strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_half_period  <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_period_valid <= w_capture;
      if (w_capture) begin
        r_half_period <= r_count;
      end
    end
  end

  // Registered detection flag follows the state one clock later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_siren <= 1'b0;
    end else begin
      r_siren <= (r_state == LOCKED);
    end
  end

  assign siren_detected = r_siren;
  assign half_period    = r_half_period;
  assign period_valid   = r_period_valid;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_siren_detector.sv
// Testbench for siren_detector with the window, timeout and lock count
// scaled down by 1000 so the run stays short:
//   MIN_HALF=65, MAX_HALF=131, TIMEOUT=262, LOCK_COUNT=8.
// Expected half-periods come from the bench's own tick count between
// tone toggles and are queued when an edge is driven.
module tb_siren_detector;
  import siren_pkg::*;

  localparam period_t    T_MIN  = 18'd65;
  localparam period_t    T_MAX  = 18'd131;
  localparam period_t    T_TO   = 18'd262;
  localparam logic [3:0] T_LOCK = 4'd8;

  logic          clock = 1'b0;
  logic          reset;
  logic          tone_in;
  logic          siren_detected;
  logic [17:0]   half_period;
  logic          period_valid;
  state_t        dbg_state;

  int            total = 0;
  int            bad = 0;
  int            since_edge = 0;
  logic [17:0]   exp_q[$];

  // Clock generation.
  always #5 clock = ~clock;

  siren_detector #(
    .MIN_HALF   (T_MIN),
    .MAX_HALF   (T_MAX),
    .TIMEOUT    (T_TO),
    .LOCK_COUNT (T_LOCK)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .tone_in        (tone_in),
    .siren_detected (siren_detected),
    .half_period    (half_period),
    .period_valid   (period_valid),
    .o_dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  // Any period_valid is matched against the scoreboard queue.
  task automatic tick();
    @(posedge clock);
    #1;
    since_edge++;
    if (period_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("pv_unexpected", 32'(period_valid), 32'd0);
      end else begin
        check("half_period", 32'(half_period), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Toggle the tone; queue the interval if the DUT should report it.
  task automatic send_edge(input bit meas);
    if (meas) exp_q.push_back(since_edge[17:0]);
    tone_in = ~tone_in;
    since_edge = 0;
  endtask

  // Wait until p cycles have passed since the last toggle, then toggle.
  task automatic gap(input int p, input bit meas);
    while (since_edge < p) tick();
    send_edge(meas);
  endtask

  initial begin
    // ---------------- reset ----------------
    tone_in = 1'b0;
    reset   = 1'b1;
    ticks(2);
    check("rst_siren", 32'(siren_detected), 32'd0);
    check("rst_pv", 32'(period_valid), 32'd0);
    check("rst_hp", 32'(half_period), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    ticks(5);

    // ---------------- 10 edges at half-period 100 ----------------
    send_edge(0);
    for (int i = 2; i <= 8; i++) gap(100, 1);
    while (since_edge < 100) tick();
    check("e9_pre_state", 32'(dbg_state), 32'(ACQUIRE));
    check("e9_pre_siren", 32'(siren_detected), 32'd0);
    send_edge(1);
    ticks(4);
    check("e9_state_locked", 32'(dbg_state), 32'(LOCKED));
    check("e9_siren_lag", 32'(siren_detected), 32'd0);
    tick();
    check("e9_siren_high", 32'(siren_detected), 32'd1);
    gap(100, 1);
    ticks(3);
    check("latency_3", 32'(period_valid), 32'd0);
    tick();
    check("latency_4", 32'(period_valid), 32'd1);

    // ---------------- timeout from LOCKED ----------------
    ticks(261);
    check("to_pre_state", 32'(dbg_state), 32'(LOCKED));
    check("to_pre_siren", 32'(siren_detected), 32'd1);
    tick();
    check("to_state_idle", 32'(dbg_state), 32'(IDLE));
    check("to_siren_lag", 32'(siren_detected), 32'd1);
    tick();
    check("to_siren_low", 32'(siren_detected), 32'd0);

    // ---------------- window boundaries ----------------
    send_edge(0);
    for (int i = 0; i < 3; i++) gap(100, 1);
    gap(64, 1);
    gap(65, 1);
    for (int i = 0; i < 6; i++) gap(100, 1);
    while (since_edge < 131) tick();
    check("b64_reset_good", 32'(siren_detected), 32'd0);
    send_edge(1);
    ticks(5);
    check("b131_lock", 32'(siren_detected), 32'd1);
    gap(132, 1);
    ticks(4);
    check("b132_state", 32'(dbg_state), 32'(ACQUIRE));
    check("b132_siren_lag", 32'(siren_detected), 32'd1);
    tick();
    check("b132_siren_low", 32'(siren_detected), 32'd0);

    // ---------------- short glitch while locked ----------------
    for (int i = 0; i < 8; i++) gap(100, 1);
    ticks(5);
    check("relock", 32'(siren_detected), 32'd1);
    gap(30, 1);
    ticks(4);
    check("short_siren_lag", 32'(siren_detected), 32'd1);
    tick();
    check("short_siren_low", 32'(siren_detected), 32'd0);
    for (int i = 0; i < 7; i++) gap(100, 1);
    while (since_edge < 100) tick();
    check("short_not_early", 32'(siren_detected), 32'd0);
    send_edge(1);
    ticks(5);
    check("short_restored", 32'(siren_detected), 32'd1);

    // ---------------- steady tone ----------------
`ifdef SIREN_SWEEP_CHECK_EN
    for (int i = 0; i < 31; i++) gap(100, 1);
    ticks(5);
    check("sweep_hold_31", 32'(siren_detected), 32'd1);
    gap(100, 1);
    ticks(5);
    check("sweep_drop_state", 32'(dbg_state), 32'(ACQUIRE));
    check("sweep_drop_siren", 32'(siren_detected), 32'd0);
`else
    for (int i = 0; i < 40; i++) gap(100, 1);
    ticks(5);
    check("steady_siren", 32'(siren_detected), 32'd1);
    check("steady_state", 32'(dbg_state), 32'(LOCKED));
`endif

    // ---------------- reset mid-interval ----------------
    if (tone_in) gap(100, 1);
    while (since_edge < 50) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_siren", 32'(siren_detected), 32'd0);
    check("mid_rst_pv", 32'(period_valid), 32'd0);
    check("mid_rst_hp", 32'(half_period), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    tick();
    reset = 1'b0;
    ticks(10);
    check("post_rst_pv", 32'(period_valid), 32'd0);
    send_edge(0);
    ticks(4);
    check("post_rst_first_pv", 32'(period_valid), 32'd0);
    check("post_rst_first_state", 32'(dbg_state), 32'(ACQUIRE));
    gap(100, 1);
    ticks(5);
    check("post_rst_measure", 32'(half_period), 32'd100);

    // ---------------- wrap-up ----------------
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
